// File: rtl/hid_report_arbiter.sv
// hid_report_arbiter: keeps the latest changed HID report per port and drains
// pending reports round-robin, word by word, into one shared display-buffer
// write port with a ready handshake.
module hid_report_arbiter #(
  parameter int unsigned C_ports        = 2,
  parameter int unsigned C_report_bytes = 8,
  parameter int unsigned C_word_bits    = 16,
  parameter int unsigned C_addr_bits    = 5
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [C_ports-1:0]                  hid_valid,
  input  logic [C_ports*C_report_bytes*8-1:0] hid_report,
  input  logic                                force_refresh,
  output logic                                wr_en,
  output logic [C_addr_bits-1:0]              wr_addr,
  output logic [C_word_bits-1:0]              wr_data,
  input  logic                                wr_ready,
  output logic [C_ports-1:0]                  pending,
  output logic                                busy,
  output logic [C_ports*8-1:0]                drop_count
);

  localparam int unsigned R  = C_report_bytes * 8;
  localparam int unsigned W  = R / C_word_bits;
  localparam int unsigned PW = (C_ports > 1) ? $clog2(C_ports) : 1;
  localparam int unsigned IW = (W > 1) ? $clog2(W) : 1;
  localparam int unsigned AW = C_addr_bits;

  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } state_t;

  state_t         state;
  logic [PW-1:0]  last_grant;
  logic [PW-1:0]  port;
  logic [IW-1:0]  idx;
  logic [R-1:0]   xfer;
  logic [R-1:0]   hold [C_ports];
  logic [7:0]     drop [C_ports];

  logic           grant_c;
  logic [PW-1:0]  grant_port_c;
  logic [C_ports-1:0] changed_c;
  logic [C_ports-1:0] granted_c;
  int             cand;

  // Round-robin pick: first pending port searching upward from last_grant+1.
  always_comb begin
    grant_c      = 1'b0;
    grant_port_c = '0;
    cand         = 0;
    for (int i = 1; i <= int'(C_ports); i++) begin
      cand = int'(last_grant) + i;
      if (cand >= int'(C_ports)) begin
        cand = cand - int'(C_ports);
      end
      if (!grant_c && (state == IDLE) && pending[PW'(cand)]) begin
        grant_c      = 1'b1;
        grant_port_c = PW'(cand);
      end
    end
  end

  // Per-port decode: a strobe only counts when it carries a different report.
  always_comb begin
    changed_c = '0;
    granted_c = '0;
    for (int p = 0; p < int'(C_ports); p++) begin
      changed_c[p] = hid_valid[p] && (hid_report[p*R +: R] != hold[p]);
      granted_c[p] = grant_c && (grant_port_c == PW'(p));
    end
  end

  // Report capture, pending flags and saturating overrun counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= '0;
      for (int p = 0; p < int'(C_ports); p++) begin
        hold[p] <= '0;
        drop[p] <= '0;
      end
    end else begin
      for (int p = 0; p < int'(C_ports); p++) begin
        if (changed_c[p]) begin
          hold[p] <= hid_report[p*R +: R];
          // Overwriting a still-waiting report loses it, unless this very
          // cycle hands the old one to the writer.
          if (pending[p] && !granted_c[p] && (drop[p] != 8'hFF)) begin
            drop[p] <= drop[p] + 8'd1;
          end
        end
        // A new report (or a refresh) in the grant cycle keeps the port pending.
        if (force_refresh || changed_c[p]) begin
          pending[p] <= 1'b1;
        end else if (granted_c[p]) begin
          pending[p] <= 1'b0;
        end
      end
    end
  end

  // Transfer FSM: snapshot the granted report, then stream it LSW first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      wr_en      <= 1'b0;
      busy       <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      xfer       <= '0;
      port       <= '0;
      idx        <= '0;
      last_grant <= PW'(C_ports - 1);
    end else begin
      case (state)
        IDLE: begin
          if (grant_c) begin
            xfer    <= hold[grant_port_c];
            port    <= grant_port_c;
            idx     <= '0;
            wr_addr <= AW'(int'(grant_port_c) * int'(W));
            wr_data <= hold[grant_port_c][C_word_bits-1:0];
            wr_en   <= 1'b1;
            busy    <= 1'b1;
            state   <= WRITE;
          end
        end
        WRITE: begin
          if (wr_ready) begin
            if (idx == IW'(W - 1)) begin
              last_grant <= port;
              wr_en      <= 1'b0;
              busy       <= 1'b0;
              state      <= IDLE;
            end else begin
              idx     <= idx + IW'(1);
              wr_addr <= wr_addr + AW'(1);
              wr_data <= xfer[(int'(idx) + 1) * int'(C_word_bits) +: C_word_bits];
            end
          end
        end
        default: begin
          state <= IDLE;
          wr_en <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Flatten the per-port counters onto the output bus.
  always_comb begin
    drop_count = '0;
    for (int p = 0; p < int'(C_ports); p++) begin
      drop_count[p*8 +: 8] = drop[p];
    end
  end

endmodule

// File: tb/tb_hid_report_arbiter.sv
// Directed bench for hid_report_arbiter (2 ports, 8-byte reports, 16-bit words).
module tb_hid_report_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic [1:0]   hid_valid;
  logic [127:0] hid_report;
  logic         force_refresh;
  logic         wr_en;
  logic [4:0]   wr_addr;
  logic [15:0]  wr_data;
  logic         wr_ready;
  logic [1:0]   pending;
  logic         busy;
  logic [15:0]  drop_count;

  int n_vec = 0;
  int n_bad = 0;

  hid_report_arbiter #(
    .C_ports(2), .C_report_bytes(8), .C_word_bits(16), .C_addr_bits(5)
  ) dut (
    .clk(clk), .rst(rst), .hid_valid(hid_valid), .hid_report(hid_report),
    .force_refresh(force_refresh), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_ready(wr_ready), .pending(pending), .busy(busy),
    .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  vld;
    logic [63:0] r0;
    logic [63:0] r1;
    logic        en;
    logic [4:0]  addr;
    logic [15:0] data;
    logic [1:0]  pend;
    logic [15:0] drop;
  } vec_t;

  vec_t tbl[$];

  localparam logic [63:0] A0 = 64'hAAAA_BBBB_CCCC_DDDD;
  localparam logic [63:0] B1 = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] A2 = 64'h1111_2222_3333_4444;
  localparam logic [63:0] B2 = 64'h5555_6666_7777_8888;
  localparam logic [63:0] D0 = 64'h1122_3344_5566_7788;
  localparam logic [63:0] E0 = 64'h0F0F_1E1E_2D2D_3C3C;
  localparam logic [63:0] F1 = 64'h9999_AAAA_BBBB_CCCC;
  localparam logic [63:0] F2 = 64'h1212_3434_5656_7878;
  localparam logic [63:0] F3 = 64'hCAFE_F00D_BABE_0001;
  localparam logic [63:0] G0 = 64'h4040_3030_2020_1010;
  localparam logic [63:0] G1 = 64'h0404_0303_0202_0101;
  localparam logic [63:0] H0 = 64'h7777_6666_5555_4444;
  localparam logic [63:0] J1 = 64'h1357_9BDF_2468_ACE0;

  task automatic add(input logic [1:0] vld, input logic [63:0] r0, input logic [63:0] r1,
                     input logic en, input logic [4:0] addr, input logic [15:0] data,
                     input logic [1:0] pend, input logic [15:0] drop);
    vec_t v;
    v.vld = vld; v.r0 = r0; v.r1 = r1; v.en = en; v.addr = addr;
    v.data = data; v.pend = pend; v.drop = drop;
    tbl.push_back(v);
  endtask

  // Four write cycles of one report with no new input, LSW first.
  task automatic add_xfer(input logic [4:0] base, input logic [63:0] d,
                          input logic [1:0] pend, input logic [15:0] drop);
    for (int k = 0; k < 4; k++) begin
      add(2'b00, 64'd0, 64'd0, 1'b1, base + 5'(k), d[16*k +: 16], pend, drop);
    end
  endtask

  task automatic check_out(input string nm, input logic en, input logic [4:0] addr,
                           input logic [15:0] data, input logic [1:0] pend,
                           input logic [15:0] drop);
    logic ok;
    ok = (wr_en === en) && (busy === en) && (pending === pend) && (drop_count === drop);
    if (en) ok = ok && (wr_addr === addr) && (wr_data === data);
    n_vec++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s: got en=%0b busy=%0b addr=%0d data=%h pend=%b drop=%h; want en=%0b addr=%0d data=%h pend=%b drop=%h",
               nm, wr_en, busy, wr_addr, wr_data, pending, drop_count, en, addr, data, pend, drop);
    end
  endtask

  task automatic check_reset(input string nm);
    n_vec++;
    if (wr_en !== 1'b0 || busy !== 1'b0 || wr_addr !== 5'd0 || wr_data !== 16'd0 ||
        pending !== 2'b00 || drop_count !== 16'd0) begin
      n_bad++;
      $display("FAIL %s: got en=%0b busy=%0b addr=%0d data=%h pend=%b drop=%h; want all zero",
               nm, wr_en, busy, wr_addr, wr_data, pending, drop_count);
    end
  endtask

  // One cycle: check current outputs at the falling edge, then drive inputs.
  task automatic cyc(input string nm, input logic [1:0] vld, input logic [63:0] r0,
                     input logic [63:0] r1, input logic frc, input logic rdy,
                     input logic en, input logic [4:0] addr, input logic [15:0] data,
                     input logic [1:0] pend, input logic [15:0] drop);
    @(negedge clk);
    check_out(nm, en, addr, data, pend, drop);
    hid_valid     = vld;
    hid_report    = {r1, r0};
    force_refresh = frc;
    wr_ready      = rdy;
  endtask

  initial begin
    rst = 1'b1; hid_valid = '0; hid_report = '0; force_refresh = 1'b0; wr_ready = 1'b1;

    // Both ports at once: port 0 first, one idle cycle, then port 1; again for a second pair.
    add(2'b11, A0, B1, 0, 0, 0, 2'b00, 0);
    add(2'b00, 0, 0, 0, 0, 0, 2'b11, 0);
    add_xfer(5'd0, A0, 2'b10, 0);
    add(2'b00, 0, 0, 0, 0, 0, 2'b10, 0);
    add_xfer(5'd4, B1, 2'b00, 0);
    add(2'b11, A2, B2, 0, 0, 0, 2'b00, 0);
    add(2'b00, 0, 0, 0, 0, 0, 2'b11, 0);
    add_xfer(5'd0, A2, 2'b10, 0);
    add(2'b00, 0, 0, 0, 0, 0, 2'b10, 0);
    add_xfer(5'd4, B2, 2'b00, 0);
    // Single report on port 0.
    add(2'b01, D0, 0, 0, 0, 0, 2'b00, 0);
    add(2'b00, 0, 0, 0, 0, 0, 2'b01, 0);
    add(2'b00, 0, 0, 1, 5'd0, 16'h7788, 2'b00, 0);
    add(2'b00, 0, 0, 1, 5'd1, 16'h5566, 2'b00, 0);
    add(2'b00, 0, 0, 1, 5'd2, 16'h3344, 2'b00, 0);
    add(2'b00, 0, 0, 1, 5'd3, 16'h1122, 2'b00, 0);
    // Duplicate of the held report: nothing happens.
    add(2'b01, D0, 0, 0, 0, 0, 2'b00, 0);
    add(2'b00, 0, 0, 0, 0, 0, 2'b00, 0);
    add(2'b00, 0, 0, 0, 0, 0, 2'b00, 0);
    // Port 1 overwritten twice while port 0 drains: two drops, third report written.
    add(2'b01, E0, 0, 0, 0, 0, 2'b00, 0);
    add(2'b00, 0, 0, 0, 0, 0, 2'b01, 0);
    add(2'b10, 0, F1, 1, 5'd0, 16'h3C3C, 2'b00, 16'h0000);
    add(2'b10, 0, F2, 1, 5'd1, 16'h2D2D, 2'b10, 16'h0000);
    add(2'b10, 0, F3, 1, 5'd2, 16'h1E1E, 2'b10, 16'h0100);
    add(2'b00, 0, 0, 1, 5'd3, 16'h0F0F, 2'b10, 16'h0200);
    add(2'b00, 0, 0, 0, 0, 0, 2'b10, 16'h0200);
    add(2'b00, 0, 0, 1, 5'd4, 16'h0001, 2'b00, 16'h0200);
    add(2'b00, 0, 0, 1, 5'd5, 16'hBABE, 2'b00, 16'h0200);
    add(2'b00, 0, 0, 1, 5'd6, 16'hF00D, 2'b00, 16'h0200);
    add(2'b00, 0, 0, 1, 5'd7, 16'hCAFE, 2'b00, 16'h0200);
    add(2'b00, 0, 0, 0, 0, 0, 2'b00, 16'h0200);
    // New report on the granted port in the grant cycle: old one written, new stays pending.
    add(2'b01, G0, 0, 0, 0, 0, 2'b00, 16'h0200);
    add(2'b01, G1, 0, 0, 0, 0, 2'b01, 16'h0200);
    add_xfer(5'd0, G0, 2'b01, 16'h0200);
    add(2'b00, 0, 0, 0, 0, 0, 2'b01, 16'h0200);
    add_xfer(5'd0, G1, 2'b00, 16'h0200);
    add(2'b00, 0, 0, 0, 0, 0, 2'b00, 16'h0200);

    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1 check_reset("reset_state");

    for (int i = 0; i < tbl.size(); i++) begin
      cyc($sformatf("vec%0d", i), tbl[i].vld, tbl[i].r0, tbl[i].r1, 1'b0, 1'b1,
          tbl[i].en, tbl[i].addr, tbl[i].data, tbl[i].pend, tbl[i].drop);
    end

    // wr_ready low for 5 cycles on word 2: address and data hold for 6 cycles.
    cyc("stall_idle", 2'b01, H0, 0, 0, 1, 0, 0, 0, 2'b00, 16'h0200);
    cyc("stall_pend", 2'b00, 0, 0, 0, 1, 0, 0, 0, 2'b01, 16'h0200);
    cyc("stall_w0",   2'b00, 0, 0, 0, 1, 1, 5'd0, 16'h4444, 2'b00, 16'h0200);
    cyc("stall_w1",   2'b00, 0, 0, 0, 1, 1, 5'd1, 16'h5555, 2'b00, 16'h0200);
    for (int k = 0; k < 6; k++) begin
      cyc($sformatf("stall_w2_%0d", k), 2'b00, 0, 0, 0, (k == 5),
          1, 5'd2, 16'h6666, 2'b00, 16'h0200);
    end
    cyc("stall_w3",   2'b00, 0, 0, 0, 1, 1, 5'd3, 16'h7777, 2'b00, 16'h0200);
    cyc("stall_done", 2'b00, 0, 0, 0, 1, 0, 0, 0, 2'b00, 16'h0200);

    // Reset during word 1, then a refresh rewrites both ports with zeros.
    cyc("rst_idle", 2'b10, 0, J1, 0, 1, 0, 0, 0, 2'b00, 16'h0200);
    cyc("rst_pend", 2'b00, 0, 0, 0, 1, 0, 0, 0, 2'b10, 16'h0200);
    cyc("rst_w0",   2'b00, 0, 0, 0, 1, 1, 5'd4, 16'hACE0, 2'b00, 16'h0200);
    cyc("rst_w1",   2'b00, 0, 0, 0, 1, 1, 5'd5, 16'h2468, 2'b00, 16'h0200);
    rst = 1'b1;
    #1 check_reset("rst_async");
    @(negedge clk);
    rst = 1'b0;
    cyc("frc_idle", 2'b00, 0, 0, 1, 1, 0, 0, 0, 2'b00, 0);
    cyc("frc_pend", 2'b00, 0, 0, 0, 1, 0, 0, 0, 2'b11, 0);
    for (int k = 0; k < 4; k++) begin
      cyc($sformatf("frc_p0_w%0d", k), 2'b00, 0, 0, 0, 1, 1, 5'(k), 16'h0000, 2'b10, 0);
    end
    cyc("frc_gap", 2'b00, 0, 0, 0, 1, 0, 0, 0, 2'b10, 0);
    for (int k = 0; k < 4; k++) begin
      cyc($sformatf("frc_p1_w%0d", k), 2'b00, 0, 0, 0, 1, 1, 5'(4 + k), 16'h0000, 2'b00, 0);
    end
    cyc("frc_done", 2'b00, 0, 0, 0, 1, 0, 0, 0, 2'b00, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
